// File: rtl/timer_multi.sv
// -----------------------------------------------------------------------------
// timer_multi
//
// Multi-channel interval timer. A single free-running prescaler produces a
// tick. Each channel counts up on ticks while enabled. When a channel's count
// equals its compare value on a tick, it sets a sticky pending flag. In
// auto-reload mode the count then restarts from 0. In one-shot mode the count
// holds at the compare value and the channel disables itself. Pending flags
// are cleared by writing 1 to STAT. They are gated by the per-channel ie bit
// to form intr_vec, and OR-ed together to form intr_expc.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high; clears all state
//   wr_en      single-cycle register write strobe
//   addr       word address: [ADDR_W-1:2] = channel, [1:0] = register
//   wdata      write data
//   rdata      combinational read data for addr
//   intr_vec   per-channel interrupt (pending & ie)
//   intr_expc  OR of intr_vec
//
// Register map, channel c < NUM_CH:
//   0 CTRL  [0]=en [1]=mode (1 = one-shot) [2]=ie
//   1 CMP   compare value
//   2 COUNT current count (writable)
//   3 STAT  [0]=pending, write-1-to-clear
// Channel NUM_CH, register 0 is PRESCALE. All other addresses read 0 and
// ignore writes.
// -----------------------------------------------------------------------------
module timer_multi #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 2,
  parameter  int PRE_W  = 8,
  localparam int ADDR_W = $clog2(NUM_CH + 1) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic [NUM_CH-1:0] intr_vec,
  output logic              intr_expc
);

  localparam int CH_W = ADDR_W - 2;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_CMP   = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_STAT  = 2'd3;

  logic [CH_W-1:0]   ch_addr;
  logic [1:0]        reg_addr;

  logic [PRE_W-1:0]  prescale;
  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic              pre_wr;

  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] ie;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] match;
  logic [WIDTH-1:0]  cmp   [NUM_CH];
  logic [WIDTH-1:0]  count [NUM_CH];

  assign ch_addr  = addr[ADDR_W-1:2];
  assign reg_addr = addr[1:0];

  assign tick   = (pre_cnt == prescale);
  assign pre_wr = wr_en && (ch_addr == CH_W'(NUM_CH)) && (reg_addr == REG_CTRL);

  // A channel matches only on a tick while enabled.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      match[i] = tick && en[i] && (count[i] == cmp[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      pre_cnt  <= '0;
      en       <= '0;
      mode     <= '0;
      ie       <= '0;
      pending  <= '0;
      // NOTE: the per-channel arrays are only a handful of flops, so they are
      // reset like any other register. rdata must read 0 after reset.
      for (int i = 0; i < NUM_CH; i++) begin
        cmp[i]   <= '0;
        count[i] <= '0;
      end
    end else begin
      // Prescaler: a PRESCALE write restarts the divider phase.
      if (pre_wr) begin
        prescale <= wdata[PRE_W-1:0];
        pre_cnt  <= '0;
      end else if (tick) begin
        pre_cnt  <= '0;
      end else begin
        pre_cnt  <= pre_cnt + PRE_W'(1);
      end

      for (int i = 0; i < NUM_CH; i++) begin
        // Timer update first, register writes afterwards.
        // NOTE: when one always_ff block makes several non-blocking
        // assignments to the same bit, the last one wins. Placing the CPU
        // writes after the timer update gives COUNT and CTRL writes priority
        // over the tick-driven changes in the same cycle.
        if (tick && en[i]) begin
          if (match[i]) begin
            if (mode[i]) en[i]    <= 1'b0;
            else         count[i] <= '0;
          end else begin
            count[i] <= count[i] + WIDTH'(1);
          end
        end

        // Sticky pending. A new match overrides a same-cycle write-1-to-clear.
        pending[i] <= match[i] |
                      (pending[i] & ~(wr_en && (ch_addr == CH_W'(i)) &&
                                      (reg_addr == REG_STAT) && wdata[0]));

        if (wr_en && (ch_addr == CH_W'(i))) begin
          case (reg_addr)
            REG_CTRL: begin
              en[i]   <= wdata[0];
              mode[i] <= wdata[1];
              ie[i]   <= wdata[2];
            end
            REG_CMP:   cmp[i]   <= wdata;
            REG_COUNT: count[i] <= wdata;
            default:   ;
          endcase
        end
      end
    end
  end

  // Read mux. Unmapped addresses fall through to the default of 0.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_addr == CH_W'(i)) begin
        case (reg_addr)
          REG_CTRL:  rdata = {{(WIDTH-3){1'b0}}, ie[i], mode[i], en[i]};
          REG_CMP:   rdata = cmp[i];
          REG_COUNT: rdata = count[i];
          default:   rdata = {{(WIDTH-1){1'b0}}, pending[i]};
        endcase
      end
    end
    if (ch_addr == CH_W'(NUM_CH) && reg_addr == REG_CTRL) begin
      rdata = WIDTH'(prescale);
    end
  end

  assign intr_vec  = pending & ie;
  assign intr_expc = |intr_vec;

endmodule

// File: tb/tb_timer_multi.sv
// -----------------------------------------------------------------------------
// tb_timer_multi
//
// Directed testbench for timer_multi with the default parameters
// (WIDTH=32, NUM_CH=2, PRE_W=8, ADDR_W=4). Inputs are driven 1 ns after a
// rising edge. Outputs are sampled in the same low-activity window. Expected
// values are worked out by hand from the register-level behaviour.
// -----------------------------------------------------------------------------
module tb_timer_multi;

  localparam logic [3:0] A_CTRL0  = 4'd0;
  localparam logic [3:0] A_CMP0   = 4'd1;
  localparam logic [3:0] A_CNT0   = 4'd2;
  localparam logic [3:0] A_STAT0  = 4'd3;
  localparam logic [3:0] A_CTRL1  = 4'd4;
  localparam logic [3:0] A_CMP1   = 4'd5;
  localparam logic [3:0] A_CNT1   = 4'd6;
  localparam logic [3:0] A_STAT1  = 4'd7;
  localparam logic [3:0] A_PRE    = 4'd8;
  localparam logic [3:0] A_HOLE   = 4'd9;
  localparam logic [3:0] A_HOLE2  = 4'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  intr_vec;
  logic        intr_expc;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  timer_multi #(.WIDTH(32), .NUM_CH(2), .PRE_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .intr_vec  (intr_vec),
    .intr_expc (intr_expc)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  // Counts edges until intr_vec[ch] is observed high. Returns 0 on timeout.
  task automatic wait_rise(input int ch, output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (intr_vec[ch]) begin
        n = k;
        return;
      end
    end
  endtask

  int n;
  int r1;

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    addr  = '0;
    wdata = '0;
    steps(3);
    reset = 1'b0;
    step();

    // Reset state
    chk_reg("rst ctrl0", A_CTRL0, 32'd0);
    chk_reg("rst cnt0", A_CNT0, 32'd0);
    chk_reg("rst stat1", A_STAT1, 32'd0);
    chk_reg("rst prescale", A_PRE, 32'd0);
    check("rst intr_expc", 32'(intr_expc), 32'd0);
    step();

    // 1: legacy 21-cycle interval, PRESCALE=0, ch0 CMP=20, CTRL=en|ie
    wr(A_CMP0, 32'd20);
    wr(A_CTRL0, 32'h5);
    wait_rise(0, n);
    check("t1 first rise edges", 32'(n), 32'd21);
    wr(A_STAT0, 32'd1);
    check("t1 w1c drops intr", 32'(intr_expc), 32'd0);
    // The W1C took one edge, so 20 more edges complete the 21-cycle period.
    wait_rise(0, n);
    check("t1 second rise edges", 32'(n), 32'd20);
    wr(A_CTRL0, 32'h0);
    wr(A_STAT0, 32'd1);

    // 2: PRESCALE=3, ch1 CMP=4, auto-reload -> period 20, count steps every 4
    wr(A_PRE, 32'd3);
    wr(A_CMP1, 32'd4);
    wr(A_CNT1, 32'd0);
    wr(A_CTRL1, 32'h5);
    wait_rise(1, n);
    check("t2 first rise seen", 32'(n != 0), 32'd1);
    r1 = cyc;
    chk_reg("t2 count k0", A_CNT1, 32'd0);
    wr(A_STAT1, 32'd1);
    steps(3 - (cyc - r1));
    chk_reg("t2 count k3", A_CNT1, 32'd0);
    step();
    chk_reg("t2 count k4", A_CNT1, 32'd1);
    steps(4);
    chk_reg("t2 count k8", A_CNT1, 32'd2);
    chk_reg("t2 stat cleared", A_STAT1, 32'd0);
    wait_rise(1, n);
    check("t2 period", 32'(cyc - r1), 32'd20);
    wr(A_CTRL1, 32'h0);
    wr(A_STAT1, 32'd1);
    wr(A_PRE, 32'd0);

    // 3: one-shot, CMP=5
    wr(A_CMP0, 32'd5);
    wr(A_CNT0, 32'd0);
    wr(A_STAT0, 32'd1);
    wr(A_CTRL0, 32'h7);
    wait_rise(0, n);
    check("t3 rise edges", 32'(n), 32'd6);
    chk_reg("t3 ctrl en cleared", A_CTRL0, 32'h6);
    chk_reg("t3 count holds", A_CNT0, 32'd5);
    steps(50);
    chk_reg("t3 count after 50", A_CNT0, 32'd5);
    wr(A_STAT0, 32'd1);
    steps(30);
    chk_reg("t3 no refire stat", A_STAT0, 32'd0);
    check("t3 no refire intr", 32'(intr_expc), 32'd0);

    // 4: W1C on the match cycle; COUNT write on a tick cycle
    wr(A_CTRL0, 32'h0);
    wr(A_STAT0, 32'd1);
    wr(A_CMP0, 32'd3);
    wr(A_CNT0, 32'd0);
    wr(A_CTRL0, 32'h1);
    steps(3);
    chk_reg("t4 count at match", A_CNT0, 32'd3);
    wr(A_STAT0, 32'd1);
    chk_reg("t4 set beats clear", A_STAT0, 32'd1);
    steps(2);
    chk_reg("t4 count before wr", A_CNT0, 32'd2);
    wr(A_CNT0, 32'd0);
    chk_reg("t4 write beats tick", A_CNT0, 32'd0);
    wr(A_CTRL0, 32'h0);
    wr(A_STAT0, 32'd1);

    // 5: ie=0 masks the output only
    wr(A_CMP0, 32'd2);
    wr(A_CNT0, 32'd0);
    wr(A_CTRL0, 32'h1);
    steps(5);
    chk_reg("t5 stat masked", A_STAT0, 32'd1);
    check("t5 intr_expc masked", 32'(intr_expc), 32'd0);
    check("t5 intr_vec masked", 32'(intr_vec), 32'd0);
    wr(A_CTRL0, 32'h5);
    check("t5 intr_expc unmasked", 32'(intr_expc), 32'd1);
    check("t5 intr_vec unmasked", 32'(intr_vec), 32'd1);

    // Unmapped addresses
    wr(A_HOLE, 32'h55);
    chk_reg("hole read", A_HOLE, 32'd0);
    chk_reg("hole2 read", A_HOLE2, 32'd0);
    chk_reg("prescale intact", A_PRE, 32'd0);
    step();

    // 6: reset mid-count, both channels running, ch0 pending
    wr(A_CMP1, 32'd1000);
    wr(A_CNT1, 32'd0);
    wr(A_CTRL1, 32'h5);
    steps(10);
    chk_reg("t6 ch1 running", A_CNT1, 32'd10);
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    step();
    chk_reg("t6 ctrl0", A_CTRL0, 32'd0);
    chk_reg("t6 cmp0", A_CMP0, 32'd0);
    chk_reg("t6 cnt0", A_CNT0, 32'd0);
    chk_reg("t6 stat0", A_STAT0, 32'd0);
    chk_reg("t6 ctrl1", A_CTRL1, 32'd0);
    step();
    chk_reg("t6 cmp1", A_CMP1, 32'd0);
    chk_reg("t6 cnt1", A_CNT1, 32'd0);
    chk_reg("t6 stat1", A_STAT1, 32'd0);
    chk_reg("t6 prescale", A_PRE, 32'd0);
    check("t6 intr_expc", 32'(intr_expc), 32'd0);
    steps(30);
    chk_reg("t6 stat0 later", A_STAT0, 32'd0);
    chk_reg("t6 stat1 later", A_STAT1, 32'd0);
    check("t6 intr_vec later", 32'(intr_vec), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
